simmem_wreq_arbiter: RTL and testbench

Round-robin arbiter that shares the single requester-side input of the delay calculator between `NumPorts` requester ports. It merges write-address, write-data-beat and read-address streams onto one stream each. An order FIFO records which port owns each granted write burst, so write-data beats, which carry no AXI identifier, are forwarded strictly in write-address grant order. It sits between the requester ports and `simmem_delay_calculator`, and exports the granted port index so response routing can tag internal identifiers.

---
 rtl/simmem_pkg.sv | 18 +
 rtl/simmem_wreq_arbiter.sv | 163 ++++++++++++++++
 tb/tb_simmem_wreq_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/simmem_pkg.sv
// Shared request types for the simulated-memory model.
package simmem_pkg;

    localparam int unsigned BurstLenW = 8;

    typedef struct packed {
        logic [3:0]           id;
        logic [15:0]          addr;
        logic [BurstLenW-1:0] burst_len;
    } waddr_t;

    typedef struct packed {
        logic [3:0]           id;
        logic [15:0]          addr;
        logic [BurstLenW-1:0] burst_len;
    } raddr_t;

endpackage

// File: rtl/simmem_wreq_arbiter.sv
// Round-robin merge of per-port AW/W/AR streams onto the delay calculator input.
// An order FIFO of granted write bursts steers identifier-less W beats in AW grant order.
module simmem_wreq_arbiter #(
    parameter int unsigned NumPorts   = 2,
    parameter int unsigned OrderDepth = 4,
    localparam int unsigned PortW     = $clog2(NumPorts)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  simmem_pkg::waddr_t [NumPorts-1:0]     waddr_i,
    input  logic [NumPorts-1:0]                   waddr_valid_i,
    output logic [NumPorts-1:0]                   waddr_ready_o,
    input  logic [NumPorts-1:0]                   wdata_valid_i,
    output logic [NumPorts-1:0]                   wdata_ready_o,
    input  simmem_pkg::raddr_t [NumPorts-1:0]     raddr_i,
    input  logic [NumPorts-1:0]                   raddr_valid_i,
    output logic [NumPorts-1:0]                   raddr_ready_o,
    output simmem_pkg::waddr_t                    waddr_o,
    output logic                                  waddr_valid_o,
    input  logic                                  waddr_ready_i,
    output logic [PortW-1:0]                      waddr_port_o,
    output logic                                  wdata_valid_o,
    input  logic                                  wdata_ready_i,
    output simmem_pkg::raddr_t                    raddr_o,
    output logic                                  raddr_valid_o,
    input  logic                                  raddr_ready_i,
    output logic [PortW-1:0]                      raddr_port_o
);

    localparam int unsigned LenW  = simmem_pkg::BurstLenW;
    localparam int unsigned AddrW = $clog2(OrderDepth);

    typedef struct packed {
        logic [PortW-1:0] port;
        logic [LenW-1:0]  len;
    } order_t;

    // Returns {found, index} of the first valid port at or after ptr, with wrap.
    function automatic logic [PortW:0] rr_pick(input logic [NumPorts-1:0] valid,
                                               input logic [PortW-1:0]    ptr);
        logic [PortW:0] res;
        int             j;
        res = '0;
        for (int i = int'(NumPorts) - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= int'(NumPorts)) j = j - int'(NumPorts);
            if (valid[PortW'(j)]) res = {1'b1, PortW'(j)};
        end
        return res;
    endfunction

    logic [PortW-1:0]               wptr_q, wptr_d, rptr_q, rptr_d;
    logic                           wlock_q, wlock_d, rlock_q, rlock_d;
    logic [PortW-1:0]               wlock_port_q, wlock_port_d, rlock_port_q, rlock_port_d;
    logic [AddrW:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    order_t [OrderDepth-1:0]        mem_q, mem_d;
    logic [LenW-1:0]                beat_cnt_q, beat_cnt_d;

    logic [PortW:0]                 wpick, rpick;
    logic                           w_found, r_found, w_elig;
    logic [PortW-1:0]               w_cand, r_cand;
    logic                           fifo_full, fifo_empty;
    logic                           aw_hs, ar_hs, w_hs, push, pop;
    order_t                         head;

    // Handshakes: a transfer happens in the cycle where valid and ready are both high;
    // a raised valid keeps its payload until that cycle, which the grant locks rely on.
    always_comb begin
        fifo_full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                     (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        head       = mem_q[rd_ptr_q[AddrW-1:0]];

        wpick = rr_pick(waddr_valid_i, wptr_q);
        rpick = rr_pick(raddr_valid_i, rptr_q);
        if (wlock_q) begin
            w_cand  = wlock_port_q;
            w_found = waddr_valid_i[wlock_port_q];
        end else begin
            w_cand  = wpick[PortW-1:0];
            w_found = wpick[PortW];
        end
        if (rlock_q) begin
            r_cand  = rlock_port_q;
            r_found = raddr_valid_i[rlock_port_q];
        end else begin
            r_cand  = rpick[PortW-1:0];
            r_found = rpick[PortW];
        end

        w_elig        = !fifo_full;
        waddr_valid_o = w_found && w_elig;
        waddr_o       = w_found ? waddr_i[w_cand] : '0;
        waddr_port_o  = w_found ? w_cand : '0;
        raddr_valid_o = r_found;
        raddr_o       = r_found ? raddr_i[r_cand] : '0;
        raddr_port_o  = r_found ? r_cand : '0;

        wdata_valid_o = !fifo_empty && wdata_valid_i[head.port];
        waddr_ready_o = '0;
        raddr_ready_o = '0;
        wdata_ready_o = '0;
        for (int p = 0; p < int'(NumPorts); p++) begin
            waddr_ready_o[p] = waddr_ready_i && w_elig && w_found && (w_cand == PortW'(p));
            raddr_ready_o[p] = raddr_ready_i && r_found && (r_cand == PortW'(p));
            wdata_ready_o[p] = wdata_ready_i && !fifo_empty && (head.port == PortW'(p));
        end

        aw_hs = waddr_valid_o && waddr_ready_i;
        ar_hs = raddr_valid_o && raddr_ready_i;
        w_hs  = wdata_valid_o && wdata_ready_i;
        // Zero-length bursts carry no W beats, so they never occupy an order slot.
        push  = aw_hs && (waddr_o.burst_len != '0);
        pop   = w_hs && ((beat_cnt_q + LenW'(1)) == head.len);
    end

    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        wlock_d      = waddr_valid_o && !waddr_ready_i;
        wlock_port_d = w_cand;
        rlock_d      = raddr_valid_o && !raddr_ready_i;
        rlock_port_d = r_cand;
        if (aw_hs) wptr_d = (w_cand == PortW'(NumPorts - 1)) ? '0 : w_cand + PortW'(1);
        if (ar_hs) rptr_d = (r_cand == PortW'(NumPorts - 1)) ? '0 : r_cand + PortW'(1);

        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q[AddrW-1:0]] = '{port: w_cand, len: waddr_o.burst_len};
        wr_ptr_d = wr_ptr_q + (AddrW+1)'(push);
        rd_ptr_d = rd_ptr_q + (AddrW+1)'(pop);

        beat_cnt_d = beat_cnt_q;
        if (pop)       beat_cnt_d = '0;
        else if (w_hs) beat_cnt_d = beat_cnt_q + LenW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            wlock_q      <= 1'b0;
            rlock_q      <= 1'b0;
            wlock_port_q <= '0;
            rlock_port_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            mem_q        <= '0;
            beat_cnt_q   <= '0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            wlock_q      <= wlock_d;
            rlock_q      <= rlock_d;
            wlock_port_q <= wlock_port_d;
            rlock_port_q <= rlock_port_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            mem_q        <= mem_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_simmem_wreq_arbiter.sv
// Bench for simmem_wreq_arbiter: directed scenarios plus a randomized run against a queue model.
module tb_simmem_wreq_arbiter;
    import simmem_pkg::*;

    localparam int NP = 2;
    localparam int OD = 4;
    localparam int EW = 1 + BurstLenW;

    logic              clk = 1'b0;
    logic              rst_n;
    waddr_t [NP-1:0]   waddr_i;
    logic   [NP-1:0]   waddr_valid_i, waddr_ready_o;
    logic   [NP-1:0]   wdata_valid_i, wdata_ready_o;
    raddr_t [NP-1:0]   raddr_i;
    logic   [NP-1:0]   raddr_valid_i, raddr_ready_o;
    waddr_t            waddr_o;
    logic              waddr_valid_o, waddr_ready_i;
    logic   [0:0]      waddr_port_o;
    logic              wdata_valid_o, wdata_ready_i;
    raddr_t            raddr_o;
    logic              raddr_valid_o, raddr_ready_i;
    logic   [0:0]      raddr_port_o;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];

    always #5 clk = ~clk;

    simmem_wreq_arbiter #(.NumPorts(NP), .OrderDepth(OD)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .waddr_i(waddr_i), .waddr_valid_i(waddr_valid_i), .waddr_ready_o(waddr_ready_o),
        .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
        .raddr_i(raddr_i), .raddr_valid_i(raddr_valid_i), .raddr_ready_o(raddr_ready_o),
        .waddr_o(waddr_o), .waddr_valid_o(waddr_valid_o), .waddr_ready_i(waddr_ready_i),
        .waddr_port_o(waddr_port_o),
        .wdata_valid_o(wdata_valid_o), .wdata_ready_i(wdata_ready_i),
        .raddr_o(raddr_o), .raddr_valid_o(raddr_valid_o), .raddr_ready_i(raddr_ready_i),
        .raddr_port_o(raddr_port_o)
    );

    // ---------------- clock / reset / driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        waddr_i = '0; waddr_valid_i = '0; wdata_valid_i = '0;
        raddr_i = '0; raddr_valid_i = '0;
        waddr_ready_i = 1'b0; wdata_ready_i = 1'b0; raddr_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic waddr_t mk_aw(input int len, input int addr);
        waddr_t a;
        a = '0;
        a.id = 4'(addr);
        a.addr = 16'(addr);
        a.burst_len = 8'(len);
        return a;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        wdata_valid_i = 2'b11; wdata_ready_i = 1'b1; waddr_ready_i = 1'b1; raddr_ready_i = 1'b1;
        @(negedge clk);
        checks++; if (waddr_valid_o !== 1'b0) begin errors++; $display("FAIL rst_waddr_valid got %0b want 0", waddr_valid_o); end
        checks++; if (waddr_o !== '0) begin errors++; $display("FAIL rst_waddr got %0h want 0", waddr_o); end
        checks++; if (waddr_port_o !== 1'b0) begin errors++; $display("FAIL rst_waddr_port got %0d want 0", waddr_port_o); end
        checks++; if (waddr_ready_o !== 2'b00) begin errors++; $display("FAIL rst_waddr_ready got %0b want 00", waddr_ready_o); end
        checks++; if (wdata_valid_o !== 1'b0) begin errors++; $display("FAIL rst_wdata_valid got %0b want 0", wdata_valid_o); end
        checks++; if (wdata_ready_o !== 2'b00) begin errors++; $display("FAIL rst_wdata_ready got %0b want 00", wdata_ready_o); end
        checks++; if (raddr_valid_o !== 1'b0) begin errors++; $display("FAIL rst_raddr_valid got %0b want 0", raddr_valid_o); end
        checks++; if (raddr_ready_o !== 2'b00) begin errors++; $display("FAIL rst_raddr_ready got %0b want 00", raddr_ready_o); end
        tick();
        idle();
    endtask

    task automatic test_aw_fairness();
        int e;
        do_reset();
        waddr_i[0] = mk_aw(0, 'h100); waddr_i[1] = mk_aw(0, 'h200);
        waddr_valid_i = 2'b11; waddr_ready_i = 1'b1;
        raddr_i[0] = '0; raddr_i[1] = '0; raddr_i[0].addr = 16'h300; raddr_i[1].addr = 16'h400;
        raddr_valid_i = 2'b11; raddr_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            e = k % 2;
            @(negedge clk);
            checks++; if (waddr_valid_o !== 1'b1) begin errors++; $display("FAIL fair_aw_valid k=%0d got %0b want 1", k, waddr_valid_o); end
            checks++; if (waddr_port_o !== 1'(e)) begin errors++; $display("FAIL fair_aw_port k=%0d got %0d want %0d", k, waddr_port_o, e); end
            checks++; if (waddr_o.addr !== (e == 1 ? 16'h200 : 16'h100)) begin errors++; $display("FAIL fair_aw_addr k=%0d got %0h", k, waddr_o.addr); end
            checks++; if (waddr_ready_o !== 2'(1 << e)) begin errors++; $display("FAIL fair_aw_ready k=%0d got %0b want %0b", k, waddr_ready_o, 2'(1 << e)); end
            checks++; if (raddr_port_o !== 1'(e)) begin errors++; $display("FAIL fair_ar_port k=%0d got %0d want %0d", k, raddr_port_o, e); end
            checks++; if (raddr_o.addr !== (e == 1 ? 16'h400 : 16'h300)) begin errors++; $display("FAIL fair_ar_addr k=%0d got %0h", k, raddr_o.addr); end
            tick();
        end
        idle();
    endtask

    task automatic test_w_ordering();
        logic [1:0] seq [6];
        seq = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b00};
        do_reset();
        wdata_valid_i = 2'b11; wdata_ready_i = 1'b1; waddr_ready_i = 1'b1;
        waddr_i[1] = mk_aw(2, 'h11); waddr_valid_i = 2'b10;
        @(negedge clk);
        checks++; if (waddr_port_o !== 1'b1) begin errors++; $display("FAIL word_aw1_port got %0d want 1", waddr_port_o); end
        checks++; if (wdata_valid_o !== 1'b0) begin errors++; $display("FAIL word_bypass_valid got %0b want 0", wdata_valid_o); end
        checks++; if (wdata_ready_o !== 2'b00) begin errors++; $display("FAIL word_bypass_ready got %0b want 00", wdata_ready_o); end
        tick();
        waddr_i[0] = mk_aw(3, 'h22); waddr_valid_i = 2'b01;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) begin
                checks++; if (waddr_port_o !== 1'b0) begin errors++; $display("FAIL word_aw0_port got %0d want 0", waddr_port_o); end
            end
            checks++; if (wdata_ready_o !== seq[i]) begin errors++; $display("FAIL word_ready i=%0d got %0b want %0b", i, wdata_ready_o, seq[i]); end
            checks++; if (wdata_valid_o !== (seq[i] != 2'b00)) begin errors++; $display("FAIL word_valid i=%0d got %0b", i, wdata_valid_o); end
            tick();
            waddr_valid_i = 2'b00;
        end
        idle();
    endtask

    task automatic test_full_fifo();
        do_reset();
        waddr_ready_i = 1'b1; wdata_ready_i = 1'b1;
        waddr_i[0] = mk_aw(1, 'h33); waddr_valid_i = 2'b01;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (waddr_valid_o !== 1'b1) begin errors++; $display("FAIL full_fill k=%0d got %0b want 1", k, waddr_valid_o); end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if (waddr_valid_o !== 1'b0) begin errors++; $display("FAIL full_stall k=%0d got %0b want 0", k, waddr_valid_o); end
            checks++; if (waddr_ready_o !== 2'b00) begin errors++; $display("FAIL full_stall_rdy k=%0d got %0b want 00", k, waddr_ready_o); end
            tick();
        end
        wdata_valid_i = 2'b01;
        @(negedge clk);
        checks++; if (wdata_ready_o !== 2'b01) begin errors++; $display("FAIL full_pop_ready got %0b want 01", wdata_ready_o); end
        checks++; if (waddr_valid_o !== 1'b0) begin errors++; $display("FAIL full_pop_cycle_aw got %0b want 0", waddr_valid_o); end
        tick();
        wdata_valid_i = 2'b00;
        @(negedge clk);
        checks++; if (waddr_valid_o !== 1'b1) begin errors++; $display("FAIL full_after_pop got %0b want 1", waddr_valid_o); end
        checks++; if (waddr_ready_o !== 2'b01) begin errors++; $display("FAIL full_after_pop_rdy got %0b want 01", waddr_ready_o); end
        tick();
        idle();
    endtask

    task automatic test_lock();
        do_reset();
        waddr_i[0] = mk_aw(0, 'h10); waddr_i[1] = mk_aw(0, 'h20);
        waddr_ready_i = 1'b1; waddr_valid_i = 2'b01;
        tick();
        waddr_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) waddr_valid_i = 2'b11;
            @(negedge clk);
            checks++; if (waddr_port_o !== 1'b0) begin errors++; $display("FAIL lock_port k=%0d got %0d want 0", k, waddr_port_o); end
            checks++; if (waddr_o.addr !== 16'h10) begin errors++; $display("FAIL lock_addr k=%0d got %0h want 10", k, waddr_o.addr); end
            checks++; if (waddr_ready_o !== 2'b00) begin errors++; $display("FAIL lock_rdy k=%0d got %0b want 00", k, waddr_ready_o); end
            tick();
        end
        waddr_ready_i = 1'b1;
        @(negedge clk);
        checks++; if (waddr_ready_o !== 2'b01) begin errors++; $display("FAIL lock_hs_rdy got %0b want 01", waddr_ready_o); end
        tick();
        @(negedge clk);
        checks++; if (waddr_port_o !== 1'b1) begin errors++; $display("FAIL lock_next_port got %0d want 1", waddr_port_o); end
        checks++; if (waddr_ready_o !== 2'b10) begin errors++; $display("FAIL lock_next_rdy got %0b want 10", waddr_ready_o); end
        tick();
        idle();
    endtask

    task automatic test_zero_len();
        do_reset();
        waddr_ready_i = 1'b1;
        waddr_i[0] = mk_aw(2, 'h40); waddr_valid_i = 2'b01;
        tick();
        waddr_i[1] = mk_aw(0, 'h50); waddr_valid_i = 2'b10;
        @(negedge clk);
        checks++; if (waddr_valid_o !== 1'b1 || waddr_port_o !== 1'b1) begin errors++; $display("FAIL zlen_fwd got v=%0b p=%0d want v=1 p=1", waddr_valid_o, waddr_port_o); end
        checks++; if (waddr_o.burst_len !== 8'd0) begin errors++; $display("FAIL zlen_len got %0d want 0", waddr_o.burst_len); end
        tick();
        waddr_i[0] = mk_aw(1, 'h60); waddr_valid_i = 2'b01;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (waddr_valid_o !== 1'b1) begin errors++; $display("FAIL zlen_fill k=%0d got %0b want 1", k, waddr_valid_o); end
            tick();
        end
        @(negedge clk);
        checks++; if (waddr_valid_o !== 1'b0) begin errors++; $display("FAIL zlen_full got %0b want 0", waddr_valid_o); end
        tick();
        idle();
    endtask

    task automatic test_async_reset();
        do_reset();
        waddr_ready_i = 1'b1; wdata_ready_i = 1'b1;
        waddr_i[0] = mk_aw(3, 'h70); waddr_valid_i = 2'b01;
        tick();
        waddr_valid_i = 2'b00; wdata_valid_i = 2'b01;
        @(negedge clk);
        checks++; if (wdata_ready_o !== 2'b01) begin errors++; $display("FAIL arst_pre got %0b want 01", wdata_ready_o); end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (wdata_ready_o !== 2'b00) begin errors++; $display("FAIL arst_ready got %0b want 00", wdata_ready_o); end
        checks++; if (wdata_valid_o !== 1'b0) begin errors++; $display("FAIL arst_valid got %0b want 0", wdata_valid_o); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        waddr_i[0] = mk_aw(0, 'h71); waddr_i[1] = mk_aw(0, 'h72); waddr_valid_i = 2'b11;
        @(negedge clk);
        checks++; if (wdata_ready_o !== 2'b00) begin errors++; $display("FAIL arst_empty got %0b want 00", wdata_ready_o); end
        checks++; if (waddr_port_o !== 1'b0) begin errors++; $display("FAIL arst_ptr got %0d want 0", waddr_port_o); end
        tick();
        idle();
    endtask

    task automatic test_random();
        int ptr_w, ptr_r, lkp_w, lkp_r, beats, wc, rc, j, hp, hlen;
        bit lk_w, lk_r, wf, rf, ev_w, ewv, whs;
        bit aw_pend [NP];
        bit ar_pend [NP];
        waddr_t aw_pay [NP];
        raddr_t ar_pay [NP];
        logic [1:0] erdy_w, erdy_r, ewr;
        do_reset();
        exp_q.delete();
        ptr_w = 0; ptr_r = 0; lkp_w = 0; lkp_r = 0; beats = 0; lk_w = 0; lk_r = 0;
        for (int p = 0; p < NP; p++) begin aw_pend[p] = 0; ar_pend[p] = 0; aw_pay[p] = '0; ar_pay[p] = '0; end
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int p = 0; p < NP; p++) begin
                if (!aw_pend[p] && $urandom_range(0, 1) == 1) begin
                    aw_pend[p] = 1; aw_pay[p] = mk_aw(int'($urandom_range(0, 3)), int'($urandom_range(0, 16'hffff)));
                end
                if (!ar_pend[p] && $urandom_range(0, 1) == 1) begin
                    ar_pend[p] = 1; ar_pay[p] = '0; ar_pay[p].addr = 16'($urandom_range(0, 16'hffff));
                    ar_pay[p].burst_len = 8'($urandom_range(0, 255));
                end
                waddr_valid_i[p] = aw_pend[p]; waddr_i[p] = aw_pay[p];
                raddr_valid_i[p] = ar_pend[p]; raddr_i[p] = ar_pay[p];
            end
            wdata_valid_i = 2'($urandom_range(0, 3));
            waddr_ready_i = ($urandom_range(0, 3) != 0);
            wdata_ready_i = ($urandom_range(0, 3) != 0);
            raddr_ready_i = ($urandom_range(0, 3) != 0);

            wf = 0; wc = 0;
            if (lk_w) begin wc = lkp_w; wf = aw_pend[wc]; end
            else for (int i = NP - 1; i >= 0; i--) begin j = (ptr_w + i) % NP; if (aw_pend[j]) begin wf = 1; wc = j; end end
            rf = 0; rc = 0;
            if (lk_r) begin rc = lkp_r; rf = ar_pend[rc]; end
            else for (int i = NP - 1; i >= 0; i--) begin j = (ptr_r + i) % NP; if (ar_pend[j]) begin rf = 1; rc = j; end end
            ev_w = wf && (exp_q.size() < OD);
            erdy_w = (ev_w && waddr_ready_i) ? 2'(1 << wc) : 2'b00;
            erdy_r = (rf && raddr_ready_i) ? 2'(1 << rc) : 2'b00;
            if (exp_q.size() == 0) begin
                ewv = 0; ewr = 2'b00; hp = 0; hlen = 0;
            end else begin
                hp = int'(exp_q[0][EW-1]); hlen = int'(exp_q[0][BurstLenW-1:0]);
                ewv = wdata_valid_i[hp]; ewr = wdata_ready_i ? 2'(1 << hp) : 2'b00;
            end

            @(negedge clk);
            checks++; if (waddr_valid_o !== ev_w) begin errors++; $display("FAIL rnd_aw_valid cyc=%0d got %0b want %0b", cyc, waddr_valid_o, ev_w); end
            checks++; if (waddr_ready_o !== erdy_w) begin errors++; $display("FAIL rnd_aw_ready cyc=%0d got %0b want %0b", cyc, waddr_ready_o, erdy_w); end
            if (wf) begin
                checks++; if (waddr_port_o !== 1'(wc) || waddr_o !== aw_pay[wc]) begin errors++; $display("FAIL rnd_aw_sel cyc=%0d got p=%0d a=%0h want p=%0d a=%0h", cyc, waddr_port_o, waddr_o, wc, aw_pay[wc]); end
            end
            checks++; if (raddr_valid_o !== rf) begin errors++; $display("FAIL rnd_ar_valid cyc=%0d got %0b want %0b", cyc, raddr_valid_o, rf); end
            checks++; if (raddr_ready_o !== erdy_r) begin errors++; $display("FAIL rnd_ar_ready cyc=%0d got %0b want %0b", cyc, raddr_ready_o, erdy_r); end
            if (rf) begin
                checks++; if (raddr_port_o !== 1'(rc) || raddr_o !== ar_pay[rc]) begin errors++; $display("FAIL rnd_ar_sel cyc=%0d got p=%0d a=%0h want p=%0d a=%0h", cyc, raddr_port_o, raddr_o, rc, ar_pay[rc]); end
            end
            checks++; if (wdata_valid_o !== ewv) begin errors++; $display("FAIL rnd_w_valid cyc=%0d got %0b want %0b", cyc, wdata_valid_o, ewv); end
            checks++; if (wdata_ready_o !== ewr) begin errors++; $display("FAIL rnd_w_ready cyc=%0d got %0b want %0b", cyc, wdata_ready_o, ewr); end

            whs = (exp_q.size() != 0) && ewv && wdata_ready_i;
            if (whs) begin
                beats++;
                if (beats == hlen) begin void'(exp_q.pop_front()); beats = 0; end
            end
            if (ev_w && waddr_ready_i) begin
                ptr_w = (wc + 1) % NP; aw_pend[wc] = 0;
                if (aw_pay[wc].burst_len != 0) exp_q.push_back({1'(wc), aw_pay[wc].burst_len});
            end
            if (rf && raddr_ready_i) begin ptr_r = (rc + 1) % NP; ar_pend[rc] = 0; end
            lk_w = ev_w && !waddr_ready_i; lkp_w = wc;
            lk_r = rf && !raddr_ready_i;   lkp_r = rc;
            tick();
        end
        idle();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_aw_fairness();
        test_w_ordering();
        test_full_fifo();
        test_lock();
        test_zero_len();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
